// File: rtl/aes_encrypt_core.sv
// -----------------------------------------------------------------------------
// aes_encrypt_core
//   Iterative AES-128 encryption core: one round every two cycles. An external
//   key schedule supplies the round key selected by SelKey one cycle after
//   SelKey changes.
//
// Ports
//   Clk        in   1    clock, rising edge
//   Rst        in   1    asynchronous active-low reset
//   Start      in   1    one-cycle request, honoured only in IDLE
//   PlainText  in   128  plaintext block, byte 0 in [127:120]
//   KeyRy      in   1    key schedule ready, sampled only in WAIT_KEY
//   RoundKey   in   128  round key for SelKey, same byte order as PlainText
//   KeyEn      out  1    key-expansion enable (WAIT_KEY)
//   SelKey     out  4    registered round-key index, 0..10
//   CipherText out  128  registered result, held until the next DONE
//   Busy       out  1    encryption in progress
//   Done       out  1    one-cycle pulse, CipherText valid
//   Err        out  1    only with AES_BUSY_ERR_EN: registered pulse when
//                        Start arrives while Busy
//
// Build option
//   AES_BUSY_ERR_EN  adds the Err output and its logic.
// -----------------------------------------------------------------------------
module aes_encrypt_core (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] PlainText,
    input  logic         KeyRy,
    input  logic [127:0] RoundKey,
    output logic         KeyEn,
    output logic [3:0]   SelKey,
    output logic [127:0] CipherText,
    output logic         Busy,
`ifdef AES_BUSY_ERR_EN
    output logic         Done,
    output logic         Err
`else
    output logic         Done
`endif
);

    typedef enum logic [2:0] {IDLE, WAIT_KEY, ADD0, FETCH, APPLY, DONE} state_t;

    // FIPS-197 forward S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Multiply by x in GF(2^8), reduction polynomial 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes, ShiftRows and (unless last) MixColumns. The state is
    // column-major: byte i sits at row i%4, column i/4.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[s[127-8*i -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                res[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                res[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return res;
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_data;
    logic [127:0] r_cipher;
    logic [3:0]   r_sel_key;
    logic [3:0]   r_round;
    logic         w_last;
    logic [127:0] w_round_out;

    assign w_last      = (r_round == 4'd10);
    assign w_round_out = aes_round(r_data, w_last) ^ RoundKey;
    assign SelKey      = r_sel_key;
    assign CipherText  = r_cipher;

    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before the edge, independent of block order.
        if (!Rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        KeyEn       = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            IDLE:     if (Start) w_state_nxt = WAIT_KEY;
            WAIT_KEY: begin
                KeyEn = 1'b1;
                Busy  = 1'b1;
                if (KeyRy) w_state_nxt = ADD0;
            end
            ADD0: begin
                Busy        = 1'b1;
                w_state_nxt = FETCH;
            end
            // One idle cycle so RoundKey catches up with the new SelKey.
            FETCH: begin
                Busy        = 1'b1;
                w_state_nxt = APPLY;
            end
            APPLY: begin
                Busy        = 1'b1;
                w_state_nxt = w_last ? DONE : FETCH;
            end
            DONE: begin
                Done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: the wide data registers are reset as well, so an aborted run
        // leaves CipherText at zero rather than a stale or partial block.
        if (!Rst) begin
            r_data    <= '0;
            r_cipher  <= '0;
            r_sel_key <= '0;
            r_round   <= '0;
        end else begin
            case (r_state)
                IDLE: if (Start) begin
                    r_data    <= PlainText;
                    r_sel_key <= 4'd0;
                end
                ADD0: begin
                    r_data    <= r_data ^ RoundKey;
                    r_round   <= 4'd1;
                    r_sel_key <= 4'd1;
                end
                APPLY: if (w_last) begin
                    // SelKey drops to 0 on entry to DONE so that 10 is held
                    // for exactly two cycles like every other round index.
                    r_cipher  <= w_round_out;
                    r_sel_key <= 4'd0;
                end else begin
                    r_data    <= w_round_out;
                    r_round   <= r_round + 4'd1;
                    r_sel_key <= r_sel_key + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef AES_BUSY_ERR_EN
    logic r_err;
    assign Err = r_err;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_err <= 1'b0;
        else      r_err <= Start && Busy;
    end
`endif

endmodule

// File: tb/tb_aes_encrypt_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_aes_encrypt_core
//   Directed bench for aes_encrypt_core using the FIPS-197 Appendix B vector.
//   A registered round-key table stands in for the key schedule.
// -----------------------------------------------------------------------------
module tb_aes_encrypt_core;

    localparam logic [127:0] PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_ALT = 128'h00112233445566778899aabbccddeeff;

    typedef enum int {T_IDLE, T_WAIT, T_ADD0, T_FETCH, T_APPLY, T_DONE} tstate_t;

    logic         Clk       = 1'b0;
    logic         Rst       = 1'b0;
    logic         Start     = 1'b0;
    logic [127:0] PlainText = '0;
    logic         KeyRy     = 1'b1;
    logic [127:0] RoundKey  = '0;
    logic         KeyEn;
    logic [3:0]   SelKey;
    logic [127:0] CipherText;
    logic         Busy;
    logic         Done;
`ifdef AES_BUSY_ERR_EN
    logic         Err;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] rk_tab [16];

    aes_encrypt_core dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .PlainText  (PlainText),
        .KeyRy      (KeyRy),
        .RoundKey   (RoundKey),
        .KeyEn      (KeyEn),
        .SelKey     (SelKey),
        .CipherText (CipherText),
        .Busy       (Busy),
`ifdef AES_BUSY_ERR_EN
        .Done       (Done),
        .Err        (Err)
`else
        .Done       (Done)
`endif
    );

    always #5 Clk = ~Clk;

    // Key schedule model: RoundKey follows SelKey with one cycle of latency.
    always @(posedge Clk) RoundKey <= rk_tab[SelKey];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected FSM state after edge k following the Start edge, with KeyRy
    // low for the first d WAIT_KEY cycles.
    function automatic tstate_t exp_state(input int k, input int d);
        int j;
        if (k <= d) return T_WAIT;
        j = k - d;
        if (j == 1) return T_ADD0;
        if (j >= 2 && j <= 21) return (j % 2 == 0) ? T_FETCH : T_APPLY;
        if (j == 22) return T_DONE;
        return T_IDLE;
    endfunction

    function automatic logic [3:0] exp_sel(input int k, input int d);
        tstate_t s;
        s = exp_state(k, d);
        if (s == T_FETCH || s == T_APPLY) return 4'((k - d) / 2);
        return 4'd0;
    endfunction

    // Drives one encryption of PT and checks every output on every cycle.
    // repulse_k: cycle at which Start is raised again with new PlainText.
    // drop_k:    cycle at which KeyRy falls after the key was accepted.
    task automatic run_enc(input int d, input int repulse_k, input int drop_k,
                           input logic [127:0] prev_ct, input string tag);
        tstate_t      es;
        logic         exp_busy;
        logic         exp_keyen;
        logic         exp_done;
        logic [3:0]   exp_sk;
        logic [127:0] exp_ct;
        PlainText = PT;
        KeyRy     = (d == 0);
        Start     = 1'b1;
        for (int k = 0; k <= 24 + d; k++) begin
            tick();
            es        = exp_state(k, d);
            exp_busy  = es inside {T_WAIT, T_ADD0, T_FETCH, T_APPLY};
            exp_keyen = (es == T_WAIT);
            exp_done  = (es == T_DONE);
            exp_sk    = exp_sel(k, d);
            exp_ct    = (k >= 22 + d) ? CT : prev_ct;
            checks++;
            if (Busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, Busy, exp_busy);
            end
            checks++;
            if (KeyEn !== exp_keyen) begin
                errors++;
                $display("FAIL %s keyen k=%0d got=%b exp=%b", tag, k, KeyEn, exp_keyen);
            end
            checks++;
            if (Done !== exp_done) begin
                errors++;
                $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, Done, exp_done);
            end
            checks++;
            if (SelKey !== exp_sk) begin
                errors++;
                $display("FAIL %s selkey k=%0d got=%0d exp=%0d", tag, k, SelKey, exp_sk);
            end
            checks++;
            if (CipherText !== exp_ct) begin
                errors++;
                $display("FAIL %s ciphertext k=%0d got=%h exp=%h", tag, k, CipherText, exp_ct);
            end
`ifdef AES_BUSY_ERR_EN
            checks++;
            if (Err !== ((repulse_k >= 0) && (k == repulse_k + 1))) begin
                errors++;
                $display("FAIL %s err k=%0d got=%b exp=%b", tag, k, Err,
                         (repulse_k >= 0) && (k == repulse_k + 1));
            end
`endif
            if (k == 0) begin
                Start     = 1'b0;
                PlainText = PT_ALT;
            end
            if (k == d) KeyRy = 1'b1;
            if (k == drop_k) KeyRy = 1'b0;
            if (k == repulse_k) begin
                Start     = 1'b1;
                PlainText = ~PT;
            end
            if (k == repulse_k + 1) Start = 1'b0;
        end
        KeyRy = 1'b1;
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({KeyEn, Busy, Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags got=%b exp=000", {KeyEn, Busy, Done});
        end
        checks++;
        if (SelKey !== 4'd0) begin
            errors++;
            $display("FAIL reset selkey got=%0d exp=0", SelKey);
        end
        checks++;
        if (CipherText !== 128'h0) begin
            errors++;
            $display("FAIL reset ciphertext got=%h exp=0", CipherText);
        end
`ifdef AES_BUSY_ERR_EN
        checks++;
        if (Err !== 1'b0) begin
            errors++;
            $display("FAIL reset err got=%b exp=0", Err);
        end
`endif
        // Released away from the edge; the very next edge samples Start.
        Rst = 1'b1;
    endtask

    task automatic test_basic();
        run_enc(0, -1, -1, 128'h0, "basic");
    endtask

    task automatic test_key_wait();
        run_enc(5, -1, -1, CT, "keywait");
    endtask

    task automatic test_selkey();
        run_enc(0, -1, -1, CT, "selkey");
    endtask

    task automatic test_busy_restart();
        // Re-pulse while SelKey=4 with new PlainText; KeyRy falls after ADD0.
        run_enc(0, 8, 5, CT, "restart");
    endtask

    task automatic test_reset_mid();
        PlainText = PT;
        KeyRy     = 1'b1;
        Start     = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 0) Start = 1'b0;
        end
        checks++;
        if (SelKey !== 4'd6 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid pre_abort got=%0d/%b exp=6/1", SelKey, Busy);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if ({KeyEn, Busy, Done, SelKey} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid async_outputs got=%b exp=0", {KeyEn, Busy, Done, SelKey});
        end
        checks++;
        if (CipherText !== 128'h0) begin
            errors++;
            $display("FAIL rstmid ciphertext got=%h exp=0", CipherText);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid held n=%0d done/busy got=%b%b exp=00", n, Done, Busy);
            end
        end
        Rst = 1'b1;
        run_enc(0, -1, -1, 128'h0, "after_rst");
    endtask

    task automatic test_done_start();
        int found;
        PlainText = PT;
        KeyRy     = 1'b1;
        Start     = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            tick();
            if (k == 0) Start = 1'b0;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL donestart in_done got=%b exp=1", Done);
        end
        Start = 1'b1;
        tick();
        checks++;
        if ({Busy, KeyEn, Done} !== 3'b000) begin
            errors++;
            $display("FAIL donestart ignored busy/keyen/done got=%b exp=000", {Busy, KeyEn, Done});
        end
`ifdef AES_BUSY_ERR_EN
        checks++;
        if (Err !== 1'b0) begin
            errors++;
            $display("FAIL donestart err got=%b exp=0", Err);
        end
`endif
        tick();
        checks++;
        if ({Busy, KeyEn} !== 2'b11) begin
            errors++;
            $display("FAIL donestart accepted busy/keyen got=%b exp=11", {Busy, KeyEn});
        end
        Start     = 1'b0;
        PlainText = PT_ALT;
        found     = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (Done === 1'b1 && found < 0) found = n;
        end
        checks++;
        if (found != 22) begin
            errors++;
            $display("FAIL donestart latency got=%0d exp=22", found);
        end
        checks++;
        if (CipherText !== CT) begin
            errors++;
            $display("FAIL donestart ciphertext got=%h exp=%h", CipherText, CT);
        end
    endtask

    initial begin
        rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 11; i < 16; i++) rk_tab[i] = '0;

        test_reset();
        test_basic();
        test_key_wait();
        test_selkey();
        test_busy_restart();
        test_reset_mid();
        test_done_start();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
